switch_input_fifo: RTL
======================

// Module: switch_input_fifo
// PURPOSE
//  Parametrised successor of the processor's switch input buffer. Captures the switch word on a
//  debounced press of the load key and queues it in a DEPTH-entry FIFO. The control unit pops the
//  queue with a one-cycle read strobe during input instructions. The head word, width-extended, is
//  driven onto the stdin input of the register-write data mux.
// PARAMETERS
//  DATA_W      16   switch word width
//  OUT_W       32   stdin width, >= DATA_W
//  DEPTH       8    FIFO entries, power of two, >= 2
//  DEB_CYCLES  16   cycles the synchronised key must stay stable before it is accepted, >= 1
//  SIGN_EXT    0    0: zero-extend to OUT_W; 1: sign-extend from bit DATA_W-1
// PORTS
//  clk          in   1                 system clock, rising edge
//  reset        in   1                 synchronous, active-low reset
//  switch       in   DATA_W            raw switch levels, asynchronous
//  switchWrite  in   1                 raw load key, active-high, asynchronous, bouncing
//  switchRead   in   1                 pop strobe from control unit, synchronous to clk
//  clrFlags     in   1                 clears overflow and underflow
//  stdin        out  OUT_W             extended FIFO head (first-word fall-through)
//  valid        out  1                 FIFO not empty
//  full         out  1                 count == DEPTH
//  count        out  $clog2(DEPTH)+1   number of stored entries
//  overflow     out  1                 sticky: a push was dropped
//  underflow    out  1                 sticky: a pop was attempted while empty
// BEHAVIOUR
//  - Reset (reset == 0 at a clk edge): all outputs and pointers go to 0, the debouncer goes to
//    released, and the synchronisers are cleared. Reset dominates every other input in that cycle.
//  - Synchronisation: switch and switchWrite each pass through 2 flops before any use.
//  - Debounce:
//    - The counter reloads to 0 on any change of the synchronised key.
//    - When the counter reaches DEB_CYCLES-1 with the key unchanged, the debounced key takes the
//      synchronised value.
//  - Push: one push per 0->1 transition of the debounced key. The pushed data is the synchronised
//    switch value in that same cycle. Holding the key never repeats the push.
//  - Push latency: a clean key press at edge 0 produces push at edge 2+DEB_CYCLES. The stored word
//    appears on stdin and valid at the next edge.
//  - Pop: when switchRead==1 and valid==1, the head is discarded at the edge. stdin then shows the
//    next entry, or 0 if the FIFO is empty.
//  - Pop while empty: no state change except underflow <= 1.
//  - Push while full and no pop: the word is dropped, overflow <= 1, and count stays DEPTH.
//  - Push and pop in the same cycle:
//    - not empty: both take effect and count is unchanged. This applies when full too, so no
//      overflow is raised.
//    - empty: push only, and underflow <= 1.
//  - Flags: if clrFlags is asserted in the same cycle that sets a flag, the set wins. Otherwise
//    clrFlags clears both flags.
//  - Pointers: log2(DEPTH)-bit read and write pointers, wrapping modulo DEPTH. count is tracked
//    separately; full and valid are derived from count.
//  - stdin: when empty, stdin == 0. Otherwise stdin = {ext, mem[rd_ptr]}, where ext is zeros or
//    copies of bit DATA_W-1 per SIGN_EXT.
//  - Storage is a register array. There is no bypass: a word pushed into an empty FIFO is readable
//    one cycle after the push edge.
// STRUCTURE
//  - Shared package cpmath_pkg: the DATA_W/OUT_W defaults, and an io_flags_t struct
//    {overflow, underflow} reused by the future display output port.
//  - Sub-module key_debounce (params DEB_CYCLES): synchroniser + counter + rise pulse. It is
//    instantiated once, for switchWrite.
//  - FIFO storage, pointers, flags and output extension live in the top module.
// TESTING
//  - Reset: hold reset=0 for 3 cycles with switchWrite=1 -> all outputs 0; no push after release
//    until the key goes low and then high again.
//  - Bounce: with DEB_CYCLES=4, toggle switchWrite every 2 cycles for 20 cycles, then hold 1 with
//    switch=16'h00A5 -> exactly one push; stdin=32'h000000A5 and count=1.
//  - Extension: SIGN_EXT=1, push 16'h8001 -> stdin=32'hFFFF8001. With SIGN_EXT=0 -> 32'h00008001.
//  - Fill and overflow: push 9 words 1..9 with DEPTH=8 -> full=1, overflow=1; 8 pops return 1..8
//    in order; then valid=0 and stdin=0.
//  - Simultaneous events:
//    - full FIFO, push and pop in the same cycle -> count stays 8, overflow stays 0, and the new
//      word is the last one read.
//    - empty FIFO, push and pop in the same cycle -> count=1, underflow=1.
//  - Wrap and clear: push/pop 20 words one at a time -> data order is preserved across pointer
//    wrap. Pulsing clrFlags clears both flags; reset mid-fill (count=5) -> count=0, stdin=0 on the
//    next cycle.

Source files
------------

// File: rtl/cpmath_pkg.sv
// Shared definitions for the processor's I/O ports: default widths and the
// sticky error-flag pair reused by the switch input and display output ports.
package cpmath_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int OUT_W_DEF  = 32;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } io_flags_t;

   // A flag being set in the same cycle as a clear request stays set.
   function automatic io_flags_t update_flags(input io_flags_t cur,
                                              input io_flags_t set,
                                              input logic      clr);
      io_flags_t nxt;
      nxt           = clr ? '0 : cur;
      nxt.overflow  = nxt.overflow  | set.overflow;
      nxt.underflow = nxt.underflow | set.underflow;
      return nxt;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for a
// bouncing mechanical key.
module key_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_rise
);

   localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deb_q, deb_d;
   logic             arm_q, arm_d;

   // NOTE: every variable gets a default before any branch, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sync1_d  = key_raw;
      sync2_d  = sync1_q;
      prev_d   = sync2_q;
      cnt_d    = cnt_q;
      deb_d    = deb_q;
      arm_d    = arm_q;
      key_rise = 1'b0;
      if (sync2_q != prev_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         deb_d = sync2_q;
         // A key held down across reset must be seen released before it may push.
         if (!sync2_q) arm_d = 1'b1;
         key_rise = sync2_q & ~deb_q & arm_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
         arm_q   <= arm_d;
      end
   end

endmodule

// File: rtl/switch_input_fifo.sv
// Switch input buffer: debounced load key pushes the synchronised switch word
// into a first-word-fall-through FIFO popped by the control unit.
module switch_input_fifo
   import cpmath_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int OUT_W      = OUT_W_DEF,
   parameter int DEPTH      = 8,
   parameter int DEB_CYCLES = 16,
   parameter int SIGN_EXT   = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        switch,
   input  logic                     switchWrite,
   input  logic                     switchRead,
   input  logic                     clrFlags,
   output logic [OUT_W-1:0]         stdin,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_W-1:0] sw_sync1_q, sw_sync1_d;
   logic [DATA_W-1:0] sw_sync2_q, sw_sync2_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   io_flags_t         flags_q, flags_d, flags_set;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              key_rise;
   logic              is_empty, is_full;
   logic              do_push, do_pop, wr_en;
   logic [DATA_W-1:0] head;
   logic [OUT_W-1:0]  head_ext;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_debounce (
      .clk      (clk),
      .reset    (reset),
      .key_raw  (switchWrite),
      .key_rise (key_rise)
   );

   always_comb begin
      sw_sync1_d = switch;
      sw_sync2_d = sw_sync1_q;
      is_empty   = (count_q == '0);
      is_full    = (count_q == DEPTH_C);
      do_pop     = switchRead & ~is_empty;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push    = key_rise & (~is_full | do_pop);
      wr_en      = do_push & reset;
      flags_set.overflow  = key_rise & is_full & ~do_pop;
      flags_set.underflow = switchRead & is_empty;
      flags_d    = update_flags(flags_q, flags_set, clrFlags);
      wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         flags_q    <= '0;
      end else begin
         sw_sync1_q <= sw_sync1_d;
         sw_sync2_q <= sw_sync2_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         flags_q    <= flags_d;
      end
   end

   // NOTE: the storage array has no reset; count gates every read, so stale
   // words are never visible and the array can map onto plain registers or RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= sw_sync2_q;
   end

   assign head = mem_q[rd_ptr_q];

   if (SIGN_EXT != 0) begin : g_sign_ext
      assign head_ext = OUT_W'($signed(head));
   end else begin : g_zero_ext
      assign head_ext = OUT_W'(head);
   end

   assign stdin     = is_empty ? '0 : head_ext;
   assign valid     = ~is_empty;
   assign full      = is_full;
   assign count     = count_q;
   assign overflow  = flags_q.overflow;
   assign underflow = flags_q.underflow;

endmodule
